debounce_pulse_gen: RTL

// - Conditions a noisy asynchronous input (button/switch) into a clean level and single-cycle edge pulses.
// - Sits directly upstream of the toggle flip-flop stage: rise_o drives its toggle input (one toggle per press).
// - Pipeline: 2-FF synchroniser, then a stability counter, then a 4-state FSM, then registered pulses.

---
 rtl/debounce_pulse_gen_if.sv | 26 ++
 rtl/debounce_pulse_gen.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/debounce_pulse_gen_if.sv
// Signal bundle between a raw button source and the debounce_pulse_gen block.
// master: drives the raw input and observes the conditioned outputs.
// slave: the debouncer, which consumes btn_in and produces the level and pulses.
interface debounce_pulse_gen_if;
  logic btn_in;
  logic level_o;
  logic rise_o;
  logic fall_o;
  logic long_o;

  modport master (
    output btn_in,
    input  level_o,
    input  rise_o,
    input  fall_o,
    input  long_o
  );

  modport slave (
    input  btn_in,
    output level_o,
    output rise_o,
    output fall_o,
    output long_o
  );
endinterface

// File: rtl/debounce_pulse_gen.sv
// Debouncer for a noisy asynchronous button/switch input.
// Stages: 2-FF synchroniser, stability counter, 4-state qualification FSM,
// and registered single-cycle rise/fall pulses. rise_o feeds the toggle
// flip-flop stage downstream, so it fires exactly once per accepted press.
// Optional long-press detection is enabled by defining DEBOUNCE_LONG_PRESS_EN;
// without it long_o is tied low.
module debounce_pulse_gen #(
  parameter int CNT_W         = 16,
  parameter int STABLE_CYCLES = 1000,
  parameter int LONG_CYCLES   = 50000
) (
  input logic                 clk,
  input logic                 rst,
  debounce_pulse_gen_if.slave bus
);

  typedef enum logic [1:0] {
    LOW    = 2'd0,
    CHK_HI = 2'd1,
    HIGH   = 2'd2,
    CHK_LO = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  // Parameter sanity: the stability counter must hold STABLE_CYCLES-1 and
  // qualification needs at least two samples; the long-press threshold must
  // also fit the counter width.
  if (STABLE_CYCLES < 2 || STABLE_CYCLES >= 2**CNT_W) begin : g_badStable
    $error("debounce_pulse_gen: STABLE_CYCLES must be >= 2 and < 2**CNT_W");
  end
  if (LONG_CYCLES >= 2**CNT_W) begin : g_badLong
    $error("debounce_pulse_gen: LONG_CYCLES must be < 2**CNT_W");
  end

  logic             r_sync1;
  logic             r_btnSync;
  logic [CNT_W-1:0] r_cnt;
  state_t           r_state;
  logic             r_level;
  logic             r_rise;
  logic             r_fall;

  // Two-flop synchroniser; r_btnSync is the only path from btn_in inward.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1   <= 1'b0;
      r_btnSync <= 1'b0;
    end else begin
      r_sync1   <= bus.btn_in;
      r_btnSync <= r_sync1;
    end
  end

  // Qualification FSM: a new level is accepted only after STABLE_CYCLES equal
  // samples; any contrary sample abandons the attempt and zeroes the counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= LOW;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      case (r_state)
        LOW: begin
          if (r_btnSync) begin
            r_state <= CHK_HI;
            r_cnt   <= CNT_ONE;
          end else begin
            r_cnt   <= '0;
          end
        end
        CHK_HI: begin
          if (!r_btnSync) begin
            r_state <= LOW;
            r_cnt   <= '0;
          end else if (r_cnt == STABLE_LAST) begin
            r_state <= HIGH;
            r_cnt   <= '0;
            r_level <= 1'b1;
            r_rise  <= 1'b1;
          end else begin
            r_cnt   <= r_cnt + CNT_ONE;
          end
        end
        HIGH: begin
          if (!r_btnSync) begin
            r_state <= CHK_LO;
            r_cnt   <= CNT_ONE;
          end else begin
            r_cnt   <= '0;
          end
        end
        CHK_LO: begin
          if (r_btnSync) begin
            r_state <= HIGH;
            r_cnt   <= '0;
          end else if (r_cnt == STABLE_LAST) begin
            r_state <= LOW;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_fall  <= 1'b1;
          end else begin
            r_cnt   <= r_cnt + CNT_ONE;
          end
        end
        default: begin
          r_state <= LOW;
          r_cnt   <= '0;
          r_level <= 1'b0;
        end
      endcase
    end
  end

  assign bus.level_o = r_level;
  assign bus.rise_o  = r_rise;
  assign bus.fall_o  = r_fall;

`ifdef DEBOUNCE_LONG_PRESS_EN
  localparam logic [CNT_W-1:0] LONG_MAX  = CNT_W'(LONG_CYCLES);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);

  logic             w_inHigh;
  logic             w_enterLow;
  logic [CNT_W-1:0] r_longCnt;
  logic             r_long;

  assign w_inHigh   = (r_state == HIGH) || (r_state == CHK_LO);
  assign w_enterLow = (r_state == CHK_LO) && !r_btnSync && (r_cnt == STABLE_LAST);

  // Long-press timer: counts while the level is high (bounces into CHK_LO
  // keep the count), saturates so long_o fires once per press, and clears
  // on the edge that accepts the release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_longCnt <= '0;
      r_long    <= 1'b0;
    end else if (!w_inHigh || w_enterLow) begin
      r_longCnt <= '0;
      r_long    <= 1'b0;
    end else if (r_longCnt != LONG_MAX) begin
      r_longCnt <= r_longCnt + CNT_ONE;
      r_long    <= (r_longCnt == LONG_LAST);
    end else begin
      r_long    <= 1'b0;
    end
  end

  assign bus.long_o = r_long;
`else
  assign bus.long_o = 1'b0;
`endif

endmodule
